// File: rtl/fifo_sync_pkg.sv
// Shared types and helpers for the asynchronous FIFO pointer synchronisers.
package fifo_sync_pkg;

  localparam int unsigned MIN_SYNC_STAGES = 2;
  localparam int unsigned MAX_SYNC_STAGES = 4;

  // Default pointer width. Helpers work on FUNC_W-bit zero-extended values.
  localparam int unsigned PTR_ADDR_WIDTH = 8;
  localparam int unsigned FUNC_W         = 32;

  typedef logic [PTR_ADDR_WIDTH:0] ptr_t;

  // Zero-extended Gray input gives the correct binary in the low bits.
  function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
    logic [FUNC_W-1:0] b;
    b[FUNC_W-1] = g[FUNC_W-1];
    for (int i = int'(FUNC_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [FUNC_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(FUNC_W); i++) begin
      c = c + {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchroniser chain; no logic between stages.
module sync_chain #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/wr_ptr_sync_full.sv
// Read-pointer synchroniser into the write domain with fill level, full/almost-full
// flags, post-reset validity and sticky pointer-integrity errors.
module wr_ptr_sync_full
  import fifo_sync_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_THRESH   = 2**ADDR_WIDTH - 4
) (
  input  logic                  wr_clk,
  input  logic                  wr_rstn,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  input  logic [ADDR_WIDTH:0]   wr_ptr_bin,
  output logic [ADDR_WIDTH:0]   rd_ptr_sync_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_sync_bin,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  full,
  output logic                  almost_full,
  output logic                  sync_valid,
  output logic                  gray_err,
  output logic                  level_err
);

  localparam int unsigned PTR_W     = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH     = 2**ADDR_WIDTH;
  localparam int unsigned VALID_CNT = SYNC_STAGES + 1;
  localparam int unsigned CNT_W     = $clog2(VALID_CNT + 1);

  generate
    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
      $error("wr_ptr_sync_full: SYNC_STAGES must be within 2..4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
      $error("wr_ptr_sync_full: AF_THRESH must be within 1..2**ADDR_WIDTH");
    end
    if (PTR_W > FUNC_W) begin : g_bad_width
      $error("wr_ptr_sync_full: ADDR_WIDTH too large for pointer helpers");
    end
  endgenerate

  logic [PTR_W-1:0] prev_gray;
  logic [CNT_W-1:0] valid_cnt;
  logic             gray_jump;
  logic             level_over;

  sync_chain #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .clk   (wr_clk),
    .rst_n (wr_rstn),
    .din   (rd_ptr_gray),
    .dout  (rd_ptr_sync_gray)
  );

  // Flags stay combinational on wr_ptr_bin so full tracks writes in the same cycle.
  assign sync_valid  = (valid_cnt == CNT_W'(VALID_CNT));
  assign fill_level  = wr_ptr_bin - rd_ptr_sync_bin;
  assign full        = (fill_level == PTR_W'(DEPTH)) || !sync_valid;
  assign almost_full = (32'(fill_level) >= AF_THRESH) || !sync_valid;
  assign level_over  = (32'(fill_level) > DEPTH);
  assign gray_jump   = (popcount(FUNC_W'(rd_ptr_sync_gray ^ prev_gray)) > 1);

  always_ff @(posedge wr_clk) begin
    if (!wr_rstn) begin
      rd_ptr_sync_bin <= '0;
      prev_gray       <= '0;
      valid_cnt       <= '0;
      gray_err        <= 1'b0;
      level_err       <= 1'b0;
    end else begin
      rd_ptr_sync_bin <= PTR_W'(gray2bin(FUNC_W'(rd_ptr_sync_gray)));
      prev_gray       <= rd_ptr_sync_gray;
      if (!sync_valid) begin
        valid_cnt <= valid_cnt + CNT_W'(1);
      end
      if (sync_valid && gray_jump) begin
        gray_err <= 1'b1;
      end
      if (sync_valid && level_over) begin
        level_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wr_ptr_sync_full.sv
// Directed bench for wr_ptr_sync_full at SYNC_STAGES=2 and 4 against a sample-history model.
module tb_wr_ptr_sync_full;

  logic       wr_clk = 1'b0;
  logic       wr_rstn;
  logic [8:0] rd_ptr_gray;
  logic [8:0] wr_ptr_bin;

  logic [8:0] a_sg, a_sb, a_fill;
  logic       a_full, a_af, a_valid, a_gerr, a_lerr;
  logic [8:0] b_sg, b_sb, b_fill;
  logic       b_full, b_af, b_valid, b_gerr, b_lerr;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Model: rd_ptr_gray sampled at each edge since reset release, newest first.
  logic [8:0] hist [$];
  bit         gerr [2];
  bit         lerr [2];

  always #5 wr_clk = ~wr_clk;

  wr_ptr_sync_full #(.ADDR_WIDTH(8), .SYNC_STAGES(2)) dut_a (
    .wr_clk(wr_clk), .wr_rstn(wr_rstn), .rd_ptr_gray(rd_ptr_gray), .wr_ptr_bin(wr_ptr_bin),
    .rd_ptr_sync_gray(a_sg), .rd_ptr_sync_bin(a_sb), .fill_level(a_fill), .full(a_full),
    .almost_full(a_af), .sync_valid(a_valid), .gray_err(a_gerr), .level_err(a_lerr)
  );

  wr_ptr_sync_full #(.ADDR_WIDTH(8), .SYNC_STAGES(4)) dut_b (
    .wr_clk(wr_clk), .wr_rstn(wr_rstn), .rd_ptr_gray(rd_ptr_gray), .wr_ptr_bin(wr_ptr_bin),
    .rd_ptr_sync_gray(b_sg), .rd_ptr_sync_bin(b_sb), .fill_level(b_fill), .full(b_full),
    .almost_full(b_af), .sync_valid(b_valid), .gray_err(b_gerr), .level_err(b_lerr)
  );

  function automatic logic [8:0] g2b(input logic [8:0] g);
    logic [8:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r = r ^ (g >> k);
    return r;
  endfunction

  function automatic logic [8:0] gray(input logic [8:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic bit e_valid(input int s);
    return hist.size() >= s + 1;
  endfunction

  function automatic logic [8:0] e_sg(input int s);
    return (hist.size() >= s) ? hist[s-1] : 9'h000;
  endfunction

  function automatic logic [8:0] e_prev(input int s);
    return (hist.size() >= s + 1) ? hist[s] : 9'h000;
  endfunction

  function automatic logic [8:0] e_sb(input int s);
    return (hist.size() >= s + 1) ? g2b(hist[s]) : 9'h000;
  endfunction

  function automatic logic [8:0] e_fill(input int s);
    return wr_ptr_bin - e_sb(s);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  // Model update on each edge, from the inputs that were stable across it.
  initial begin
    forever begin
      @(posedge wr_clk);
      if (!wr_rstn) begin
        hist.delete();
        for (int j = 0; j < 2; j++) begin
          gerr[j] = 0;
          lerr[j] = 0;
        end
      end else begin
        for (int j = 0; j < 2; j++) begin
          int s;
          s = (j == 0) ? 2 : 4;
          if (e_valid(s) && $countones(e_sg(s) ^ e_prev(s)) > 1) gerr[j] = 1;
          if (e_valid(s) && e_fill(s) > 9'd256) lerr[j] = 1;
        end
        hist.push_front(rd_ptr_gray);
        if (hist.size() > 6) void'(hist.pop_back());
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge wr_clk);
      if (chk_en) begin
        cmp("m_a_sync_gray", 32'(a_sg), 32'(e_sg(2)));
        cmp("m_a_sync_bin",  32'(a_sb), 32'(e_sb(2)));
        cmp("m_a_fill",      32'(a_fill), 32'(e_fill(2)));
        cmp("m_a_full",      32'(a_full), 32'((e_fill(2) == 9'd256) || !e_valid(2)));
        cmp("m_a_af",        32'(a_af), 32'((e_fill(2) >= 9'd252) || !e_valid(2)));
        cmp("m_a_valid",     32'(a_valid), 32'(e_valid(2)));
        cmp("m_a_gerr",      32'(a_gerr), 32'(gerr[0]));
        cmp("m_a_lerr",      32'(a_lerr), 32'(lerr[0]));
        cmp("m_b_sync_gray", 32'(b_sg), 32'(e_sg(4)));
        cmp("m_b_sync_bin",  32'(b_sb), 32'(e_sb(4)));
        cmp("m_b_fill",      32'(b_fill), 32'(e_fill(4)));
        cmp("m_b_full",      32'(b_full), 32'((e_fill(4) == 9'd256) || !e_valid(4)));
        cmp("m_b_af",        32'(b_af), 32'((e_fill(4) >= 9'd252) || !e_valid(4)));
        cmp("m_b_valid",     32'(b_valid), 32'(e_valid(4)));
        cmp("m_b_gerr",      32'(b_gerr), 32'(gerr[1]));
        cmp("m_b_lerr",      32'(b_lerr), 32'(lerr[1]));
      end
    end
  end

  initial begin
    wr_rstn     = 1'b0;
    rd_ptr_gray = 9'h000;
    wr_ptr_bin  = 9'h000;
    tick(2);
    chk_en = 1;
    settle;
    cmp("rst_full",  32'(a_full), 32'd1);
    cmp("rst_af",    32'(a_af), 32'd1);
    cmp("rst_valid", 32'(a_valid), 32'd0);
    cmp("rst_fill",  32'(a_fill), 32'h000);
    cmp("rst_gerr",  32'(a_gerr), 32'd0);
    cmp("rst_lerr",  32'(a_lerr), 32'd0);

    // Release: S=2 qualifies on edge 3, S=4 on edge 5.
    wr_rstn = 1'b1;
    tick(1); settle;
    cmp("e1_full",  32'(a_full), 32'd1);
    cmp("e1_valid", 32'(a_valid), 32'd0);
    tick(1); settle;
    cmp("e2_full",  32'(a_full), 32'd1);
    tick(1); settle;
    cmp("e3_valid", 32'(a_valid), 32'd1);
    cmp("e3_full",  32'(a_full), 32'd0);
    cmp("e3_fill",  32'(a_fill), 32'h000);
    cmp("e3_b_valid", 32'(b_valid), 32'd0);
    tick(2); settle;
    cmp("e5_b_valid", 32'(b_valid), 32'd1);
    cmp("e5_b_full",  32'(b_full), 32'd0);

    // Full at half wrap, released by a read three edges later.
    wr_ptr_bin = 9'h100;
    settle;
    cmp("wr100_full", 32'(a_full), 32'd1);
    cmp("wr100_af",   32'(a_af), 32'd1);
    cmp("wr100_fill", 32'(a_fill), 32'h100);
    rd_ptr_gray = gray(9'h001);
    tick(2); settle;
    cmp("rd1_e2_full", 32'(a_full), 32'd1);
    cmp("rd1_e2_sg",   32'(a_sg), 32'h001);
    tick(1); settle;
    cmp("rd1_e3_full", 32'(a_full), 32'd0);
    cmp("rd1_e3_fill", 32'(a_fill), 32'h0FF);
    cmp("rd1_e3_b_sb", 32'(b_sb), 32'h000);
    tick(1); settle;
    cmp("rd1_e4_b_sb", 32'(b_sb), 32'h000);
    tick(1); settle;
    cmp("rd1_e5_b_sb",   32'(b_sb), 32'h001);
    cmp("rd1_e5_b_fill", 32'(b_fill), 32'h0FF);

    // Wrap-around subtraction.
    rd_ptr_gray = gray(9'h1FE);
    wr_ptr_bin  = 9'h002;
    tick(6); settle;
    cmp("wrap_model_fill", 32'(e_fill(2)), 32'd4);
    cmp("wrap_fill",   32'(a_fill), 32'd4);
    cmp("wrap_full",   32'(a_full), 32'd0);
    cmp("wrap_af",     32'(a_af), 32'd0);
    cmp("wrap_b_fill", 32'(b_fill), 32'd4);
    cmp("wrap_gerr",   32'(a_gerr), 32'd0);

    // Reset mid-run with an overrun write pointer parked.
    wr_rstn     = 1'b0;
    rd_ptr_gray = 9'h000;
    wr_ptr_bin  = 9'h105;
    tick(1); settle;
    cmp("mrst_sg",    32'(a_sg), 32'h000);
    cmp("mrst_sb",    32'(a_sb), 32'h000);
    cmp("mrst_valid", 32'(a_valid), 32'd0);
    cmp("mrst_full",  32'(a_full), 32'd1);
    cmp("mrst_af",    32'(a_af), 32'd1);
    cmp("mrst_fill",  32'(a_fill), 32'h105);
    cmp("mrst_lerr",  32'(a_lerr), 32'd0);
    cmp("mrst_b_valid", 32'(b_valid), 32'd0);
    wr_rstn = 1'b1;
    tick(3); settle;
    cmp("ov_e3_valid", 32'(a_valid), 32'd1);
    cmp("ov_e3_lerr",  32'(a_lerr), 32'd0);
    cmp("ov_e3_full",  32'(a_full), 32'd0);
    cmp("ov_e3_af",    32'(a_af), 32'd1);
    tick(1); settle;
    cmp("ov_e4_lerr",   32'(a_lerr), 32'd1);
    cmp("ov_e4_b_lerr", 32'(b_lerr), 32'd0);
    tick(2); settle;
    cmp("ov_e6_b_lerr", 32'(b_lerr), 32'd1);
    wr_ptr_bin = 9'h000;
    tick(2); settle;
    cmp("ov_sticky_a", 32'(a_lerr), 32'd1);
    cmp("ov_sticky_b", 32'(b_lerr), 32'd1);

    // Two-bit Gray jump after qualification.
    rd_ptr_gray = 9'h003;
    tick(2); settle;
    cmp("gj_e2_sg",   32'(a_sg), 32'h003);
    cmp("gj_e2_gerr", 32'(a_gerr), 32'd0);
    tick(1); settle;
    cmp("gj_e3_gerr", 32'(a_gerr), 32'd1);
    tick(2); settle;
    cmp("gj_e5_b_gerr",  32'(b_gerr), 32'd1);
    cmp("gj_sticky_a",   32'(a_gerr), 32'd1);
    tick(2); settle;
    cmp("gj_sticky_a2",  32'(a_gerr), 32'd1);

    // Reset clears sticky errors; validity re-qualifies.
    wr_rstn    = 1'b0;
    wr_ptr_bin = 9'h002;
    tick(1); settle;
    cmp("rr_gerr",   32'(a_gerr), 32'd0);
    cmp("rr_lerr",   32'(a_lerr), 32'd0);
    cmp("rr_b_gerr", 32'(b_gerr), 32'd0);
    cmp("rr_valid",  32'(a_valid), 32'd0);
    cmp("rr_full",   32'(a_full), 32'd1);
    cmp("rr_fill",   32'(a_fill), 32'h002);
    wr_rstn = 1'b1;
    tick(2); settle;
    cmp("rr_e2_valid", 32'(a_valid), 32'd0);
    tick(1); settle;
    cmp("rr_e3_valid", 32'(a_valid), 32'd1);
    cmp("rr_e3_sb",    32'(a_sb), 32'h002);
    cmp("rr_e3_fill",  32'(a_fill), 32'h000);
    cmp("rr_e3_gerr",  32'(a_gerr), 32'd0);
    tick(2); settle;
    cmp("rr_e5_b_valid", 32'(b_valid), 32'd1);
    cmp("rr_e5_b_gerr",  32'(b_gerr), 32'd0);
    tick(3); settle;
    cmp("end_full", 32'(a_full), 32'd0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
